store_buffer: RTL

- FIFO of committed stores sitting between the memory-stage store capture outputs and the data memory/cache write port.
- Accepts one store per cycle from the memory stage, drains the oldest store to memory over a valid/ready handshake, and forwards youngest-matching store data to loads.
- Signals a stall when a load partially overlaps a buffered store that it cannot forward from.

---
 rtl/store_buffer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// Committed-store FIFO between the memory stage and the data memory write port.
// Drains the oldest entry over valid/ready and forwards youngest-matching data to loads.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture_store,
  input  logic [31:0] store_addr_in,
  input  logic [31:0] store_data_in,
  input  logic [3:0]  store_byte_en_in,
  output logic        buffer_full,
  output logic        buffer_empty,
  input  logic        load_request,
  input  logic [31:0] load_addr,
  input  logic [2:0]  load_type,
  output logic        buffer_forward_valid,
  output logic [31:0] buffer_forward_data,
  output logic        forward_stall,
  output logic        mem_write_valid,
  input  logic        mem_write_ready,
  output logic [31:0] mem_write_addr,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_write_strb
);
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } entry_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  entry_t             ent [DEPTH];
  logic [DEPTH-1:0]   vld;
  logic [PTR_W-1:0]   head, tail;
  logic [PTR_W:0]     count;
  logic               push, pop;
  entry_t             hd;

  function automatic logic [2:0] be_size(input logic [3:0] be);
    return be[3] ? 3'd4 : (be[1] ? 3'd2 : 3'd1);
  endfunction

  assign buffer_full     = (count == FULL_CNT);
  assign buffer_empty    = (count == '0);
  assign mem_write_valid = !buffer_empty;
  assign pop  = mem_write_valid && mem_write_ready;
  assign push = capture_store && (|store_byte_en_in) && (!buffer_full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      vld   <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      // Clear before set: when full and popping, head == tail and the new entry must win.
      if (pop) begin
        vld[head] <= 1'b0;
        head      <= head + 1'b1;
      end
      if (push) begin
        ent[tail] <= '{addr: store_addr_in, data: store_data_in, be: store_byte_en_in};
        vld[tail] <= 1'b1;
        tail      <= tail + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign hd             = ent[head];
  assign mem_write_addr = buffer_empty ? 32'h0 : {hd.addr[31:2], 2'b00};
  assign mem_write_data = buffer_empty ? 32'h0 : hd.data << {hd.addr[1:0], 3'b000};
  assign mem_write_strb = buffer_empty ? 4'h0  : hd.be << hd.addr[1:0];

  logic             ld_en, hit, exact;
  logic [2:0]       lsize;
  logic [PTR_W-1:0] sel;
  logic [31:0]      fd;

  always_comb begin
    ld_en = load_request && (load_type inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    case (load_type[1:0])
      2'b00:   lsize = 3'd1;
      2'b01:   lsize = 3'd2;
      default: lsize = 3'd4;
    endcase
    hit = 1'b0;
    sel = '0;
    // Walk oldest to youngest so the last intersecting entry is the youngest.
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] idx;
      logic [32:0]      ea, la;
      idx = head + PTR_W'(i);
      ea  = {1'b0, ent[idx].addr};
      la  = {1'b0, load_addr};
      if (vld[idx] && (ea < la + 33'(lsize)) && (la < ea + 33'(be_size(ent[idx].be)))) begin
        hit = 1'b1;
        sel = idx;
      end
    end
    exact = (ent[sel].addr == load_addr) && (be_size(ent[sel].be) >= lsize);
    fd    = ent[sel].data;
    case (load_type)
      3'b000:  fd = {{24{fd[7]}}, fd[7:0]};
      3'b001:  fd = {{16{fd[15]}}, fd[15:0]};
      3'b100:  fd = {24'h0, fd[7:0]};
      3'b101:  fd = {16'h0, fd[15:0]};
      default: fd = fd;
    endcase
    buffer_forward_valid = ld_en && hit && exact;
    forward_stall        = ld_en && hit && !exact;
    buffer_forward_data  = buffer_forward_valid ? fd : 32'h0;
  end
endmodule
